// File: rtl/jk_pkg.sv
// Shared types and constants for the JK flop command driver.
//   jk_cmd_t       : {j,k} command encoding (hold / reset / set / toggle)
//   jk_drv_state_t : driver FSM states
//   ERR_MAX        : saturation value of the error counter
//   jk_next()      : JK characteristic function, used as the reference model
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jk_drv_state_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Next q of a JK flop given current q and the applied {j,k}.
  function automatic logic jk_next(input logic q, input jk_cmd_t c);
    logic r;
    case (c)
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO holding 2-bit JK commands.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_din (ignored while full)
//   i_pop      : drop the head entry (ignored while empty)
//   i_din      : command to write
//   o_dout     : head entry (valid while !o_empty)
//   o_full     : DEPTH entries stored
//   o_empty    : no entries stored
//   o_count    : number of stored entries, 0..DEPTH
module jk_cmd_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [1:0]    i_din,
  output logic [1:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow; the
  // extra count bit is what separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_driver.sv
// Command-driven stimulus and checker for the JK flop.
// Commands are buffered, each turned into a one-cycle {j,k} pulse, and the
// flop's returned q/q_bar compared against an internal prediction.
// Ports:
//   clk, rst_n          : clock shared with the flop, async active-low reset
//   i_cmd_valid/o_cmd_ready/i_cmd : command handshake, {j,k} encoding
//   o_j, o_k            : registered drive to the flop
//   i_q_in, i_q_bar_in  : flop outputs
//   o_busy              : work pending (FIFO non-empty or FSM not IDLE)
//   o_fifo_count        : buffered commands
//   i_err_clr           : synchronous clear of o_mismatch / o_err_count
//   o_mismatch          : sticky compare-failure flag
//   o_err_count         : saturating count of failed compares
//   o_state             : current FSM state (debug)
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both 1. o_cmd_ready is !full from registered state only;
// upstream must hold i_cmd stable while i_cmd_valid is high and not accepted.
module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  bit CHECK_EN = 1'b1,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [1:0]    i_cmd,
  output logic          o_j,
  output logic          o_k,
  input  logic          i_q_in,
  input  logic          i_q_bar_in,
  output logic          o_busy,
  output logic [CW-1:0] o_fifo_count,
  input  logic          i_err_clr,
  output logic          o_mismatch,
  output logic [7:0]    o_err_count,
  output logic [1:0]    o_state
);

  jk_drv_state_t r_state;
  jk_drv_state_t w_state_nxt;
  logic          r_j;
  logic          r_k;
  logic          r_pred;
  logic          r_mismatch;
  logic [7:0]    r_err_count;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_fail;
  logic [1:0]    w_head;
  logic [1:0]    w_jk_nxt;

  assign w_push = i_cmd_valid & ~w_full;

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_cmd),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // CHECK pops straight into DRIVE so back-to-back commands take two cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_jk_nxt    = 2'b00;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_jk_nxt    = w_head;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: w_state_nxt = CHECK;
      CHECK: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_jk_nxt    = w_head;
          w_state_nxt = DRIVE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The flop samples j,k at the end of DRIVE; pred advances on that same edge
  // so that during CHECK it names the value the flop should now hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_j    <= 1'b0;
      r_k    <= 1'b0;
      r_pred <= 1'b0;
    end else begin
      r_j <= w_jk_nxt[1];
      r_k <= w_jk_nxt[0];
      if (r_state == DRIVE) r_pred <= jk_next(r_pred, jk_cmd_t'({r_j, r_k}));
    end
  end

  assign w_fail = CHECK_EN && (r_state == CHECK) &&
                  ((i_q_in != r_pred) || (i_q_bar_in == i_q_in));

  // A failure coinciding with err_clr wins and restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch  <= 1'b0;
      r_err_count <= 8'd0;
    end else if (w_fail) begin
      r_mismatch <= 1'b1;
      if (i_err_clr)                   r_err_count <= 8'd1;
      else if (r_err_count != ERR_MAX) r_err_count <= r_err_count + 8'd1;
    end else if (i_err_clr) begin
      r_mismatch  <= 1'b0;
      r_err_count <= 8'd0;
    end
  end

  assign o_cmd_ready = ~w_full;
  assign o_j         = r_j;
  assign o_k         = r_k;
  assign o_busy      = ~w_empty | (r_state != IDLE);
  assign o_mismatch  = r_mismatch;
  assign o_err_count = r_err_count;
  assign o_state     = r_state;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: a behavioural JK flop closes the loop, a
// timestamp-based model predicts every output each cycle, and a second
// instance with the checker disabled runs on the same stimulus.
module tb_jk_cmd_driver;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic          err_clr = 1'b0;
  logic          q_in, q_bar_in;
  logic          o_cmd_ready, o_j, o_k, o_busy, o_mismatch;
  logic [CW-1:0] o_fifo_count;
  logic [7:0]    o_err_count;
  logic [1:0]    o_state;
  logic          n_cmd_ready, n_j, n_k, n_busy, n_mismatch;
  logic [CW-1:0] n_fifo_count;
  logic [7:0]    n_err_count;
  logic [1:0]    n_state;

  jk_cmd_driver #(.DEPTH(DEPTH), .CHECK_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(cmd), .o_j(o_j), .o_k(o_k), .i_q_in(q_in), .i_q_bar_in(q_bar_in),
    .o_busy(o_busy), .o_fifo_count(o_fifo_count), .i_err_clr(err_clr),
    .o_mismatch(o_mismatch), .o_err_count(o_err_count), .o_state(o_state)
  );

  jk_cmd_driver #(.DEPTH(DEPTH), .CHECK_EN(1'b0)) u_dut_nochk (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(n_cmd_ready),
    .i_cmd(cmd), .o_j(n_j), .o_k(n_k), .i_q_in(q_in), .i_q_bar_in(q_bar_in),
    .o_busy(n_busy), .o_fifo_count(n_fifo_count), .i_err_clr(err_clr),
    .o_mismatch(n_mismatch), .o_err_count(n_err_count), .o_state(n_state)
  );

  // Behavioural JK flop on the same clock and reset; frc overrides its outputs.
  logic fq;
  logic frc = 1'b0, frc_q = 1'b0, frc_qb = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fq <= 1'b0;
    else case ({o_j, o_k})
      2'b01:   fq <= 1'b0;
      2'b10:   fq <= 1'b1;
      2'b11:   fq <= ~fq;
      default: fq <= fq;
    endcase
  end
  assign q_in     = frc ? frc_q  : fq;
  assign q_bar_in = frc ? frc_qb : ~fq;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit jk_ref(input bit p, input logic [1:0] c);
    if (c == 2'b00) return p;
    if (c == 2'b01) return 1'b0;
    if (c == 2'b10) return 1'b1;
    return !p;
  endfunction

  // Model: commands wait in exp_q with their acceptance edge. A command may
  // start driving on an edge at least one after it arrived and at least two
  // after the previous start; its compare lands two edges after it starts.
  logic [1:0] exp_q[$];
  int         arr_q[$];
  bit         q_log[$];
  int         m_cyc, m_last, m_err;
  bit         m_mis, m_pred, m_fail;
  logic [1:0] m_jk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete(); arr_q.delete();
      m_cyc = 0; m_last = -100; m_err = 0; m_mis = 0; m_pred = 0; m_jk = 2'b00;
    end else begin
      m_cyc++;
      if (cmd_valid && exp_q.size() < DEPTH) begin
        exp_q.push_back(cmd);
        arr_q.push_back(m_cyc);
      end
      if (m_last == m_cyc - 2) begin
        q_log.push_back(q_in);
        m_fail = (q_in != m_pred) || (q_bar_in == q_in);
        if (m_fail) begin
          m_mis = 1;
          m_err = err_clr ? 1 : (m_err >= 255 ? 255 : m_err + 1);
        end else if (err_clr) begin
          m_mis = 0; m_err = 0;
        end
      end else if (err_clr) begin
        m_mis = 0; m_err = 0;
      end
      m_jk = 2'b00;
      if (exp_q.size() > 0 && arr_q[0] < m_cyc && m_cyc >= m_last + 2) begin
        m_jk = exp_q.pop_front();
        void'(arr_q.pop_front());
        m_last = m_cyc;
        m_pred = jk_ref(m_pred, m_jk);
      end
    end
  end

  // Compare process: every cycle, 1 time unit after the active edge.
  bit chk_on = 0;
  bit saw_full = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n && chk_on) begin : cmp
      bit e_busy;
      e_busy = (exp_q.size() > 0) || (m_last == m_cyc) || (m_last == m_cyc - 1);
      chk("j",     32'(o_j),          32'(m_jk[1]));
      chk("k",     32'(o_k),          32'(m_jk[0]));
      chk("ready", 32'(o_cmd_ready),  32'(exp_q.size() < DEPTH));
      chk("count", 32'(o_fifo_count), 32'(exp_q.size()));
      chk("busy",  32'(o_busy),       32'(e_busy));
      chk("mis",   32'(o_mismatch),   32'(m_mis));
      chk("err",   32'(o_err_count),  32'(m_err));
      chk("nc_j",  32'({n_j, n_k}),   32'(m_jk));
      chk("nc_count", 32'(n_fifo_count), 32'(exp_q.size()));
      chk("nc_mis", 32'({n_mismatch, n_err_count}), 32'(0));
      if (o_fifo_count == CW'(DEPTH) && !o_cmd_ready) saw_full = 1;
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic push(input logic [1:0] c);
    int n = 0;
    cmd_valid = 1'b1;
    cmd = c;
    while (!o_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: ready stuck low");
    end
    @(negedge clk);
  endtask

  task automatic idle_wait();
    int n = 0;
    cmd_valid = 1'b0;
    @(negedge clk);
    while (o_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 1000) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0d expected 0", o_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_j"},     32'({o_j, o_k}), 32'(0));
    chk({tag, "_count"}, 32'(o_fifo_count), 32'(0));
    chk({tag, "_ready"}, 32'(o_cmd_ready), 32'(1));
    chk({tag, "_busy"},  32'(o_busy), 32'(0));
    chk({tag, "_mis"},   32'(o_mismatch), 32'(0));
    chk({tag, "_err"},   32'(o_err_count), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    chk_on = 1;
    @(negedge clk);

    // Directed sequence against a correct flop: q must go 1,0,1,0.
    q_log.delete();
    push(2'b10); push(2'b01); push(2'b11); push(2'b11);
    idle_wait();
    chk("seq_len", 32'(q_log.size()), 32'(4));
    if (q_log.size() == 4) begin
      chk("seq_q0", 32'(q_log[0]), 32'(1));
      chk("seq_q1", 32'(q_log[1]), 32'(0));
      chk("seq_q2", 32'(q_log[2]), 32'(1));
      chk("seq_q3", 32'(q_log[3]), 32'(0));
    end
    chk("seq_mis", 32'(o_mismatch), 32'(0));
    chk("seq_err", 32'(o_err_count), 32'(0));

    // Burst faster than the drain rate must fill the FIFO.
    for (int i = 0; i < 8; i++) push(2'($urandom_range(0, 3)));
    idle_wait();
    chk("burst_full", 32'(saw_full), 32'(1));

    // Flop tied to q=0: three sets fail three times.
    frc = 1'b1; frc_q = 1'b0; frc_qb = 1'b1;
    push(2'b10); push(2'b10); push(2'b10);
    idle_wait();
    chk("tie_mis", 32'(o_mismatch), 32'(1));
    chk("tie_err", 32'(o_err_count), 32'(3));

    // Saturation, then err_clr in a failing CHECK cycle.
    for (int i = 0; i < 300; i++) push(2'b10);
    idle_wait();
    chk("sat_err", 32'(o_err_count), 32'(255));
    push(2'b10);
    cmd_valid = 1'b0;
    n = 0;
    while (!(m_last == m_cyc - 1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    idle_wait();
    chk("clr_err", 32'(o_err_count), 32'(1));
    chk("clr_mis", 32'(o_mismatch), 32'(1));
    frc = 1'b0;

    // Reset mid-operation with commands queued.
    for (int i = 0; i < 6; i++) push(2'b11);
    cmd_valid = 1'b0;
    chk("pre_rst_count", 32'(o_fifo_count >= CW'(2)), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 32'(o_fifo_count), 32'(0));
    q_log.delete();
    push(2'b11);
    idle_wait();
    chk("post_rst_q", 32'(q_log.size() > 0 ? q_log[0] : 1'b0), 32'(1));
    chk("post_rst_mis", 32'(o_mismatch), 32'(0));

    // Randomised traffic with occasional forced flop faults and clears.
    for (int i = 0; i < 800; i++) begin
      if (!(cmd_valid && !o_cmd_ready)) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd = 2'($urandom_range(0, 3));
      end
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        frc    = ~frc;
        frc_q  = 1'($urandom_range(0, 1));
        frc_qb = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    err_clr = 1'b0;
    frc = 1'b0;
    idle_wait();

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time guard.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jk_cmd_driver.md
# jk_cmd_driver

Command-driven stimulus stage that feeds the team's JK flip-flop (`jk`). It accepts hold/reset/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO. Each command becomes a one-cycle J/K pulse, and the block checks the flop's returned `q`/`q_bar` against an internal reference model. It sits directly upstream of `jk`, shares its clock, and reports mismatches through a sticky flag and a saturating error counter.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `CHECK_EN`, 1: 1 = compare flop outputs; 0 = checker disabled (`mismatch`/`err_count` held at 0).

- `clk` in 1: single clock, rising edge. Same clock as the `jk` flop.
- `rst_n` in 1: asynchronous, active-low reset. The same net resets `jk`.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept; equals !full.
- `cmd` in 2: {j,k} encoding. 00 hold, 01 reset, 10 set, 11 toggle.
- `j`, `k` out 1 each: registered drive to the flop.
- `q_in`, `q_bar_in` in 1 each: flop outputs.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `fifo_count` out $clog2(DEPTH)+1: number of buffered commands.
- `err_clr` in 1: synchronous clear of `mismatch` and `err_count`.
- `mismatch` out 1: sticky; a compare has failed.
- `err_count` out 8: failed compares, saturating at 255.

## Operation
- Push: a command enters the FIFO when `cmd_valid && cmd_ready` at a clock edge. Commands offered while full are not accepted; upstream holds them.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register {j,k} = cmd, and go to DRIVE.
  - DRIVE: j,k are stable for exactly one cycle; the flop samples them at the end of this cycle. Update `pred` per the JK table: 00 keep, 01 → 0, 10 → 1, 11 → ~pred. Set j,k to 00 and go to CHECK.
  - CHECK: compare. Failure = (`q_in` != `pred`) or (`q_bar_in` != ~`q_in`). Then:
    - FIFO non-empty: pop the next command, drive it, and go straight to DRIVE.
    - FIFO empty: go to IDLE.
- j,k are 00 in every state except DRIVE.
- Compare failure: set `mismatch`; increment `err_count`, saturating at 255. Both are gated by CHECK_EN.
- `err_clr` in the same cycle as a failure: the failure wins, giving `mismatch`=1 and `err_count`=1.
- Push and pop in the same cycle: allowed; `fifo_count` is unchanged.
- Pop never occurs when the FIFO is empty.

## Timing
- Reset values (asynchronous):
  - j=0, k=0, `pred`=0 (matches the flop's reset q=0).
  - FSM in IDLE; FIFO empty, so `fifo_count`=0 and `cmd_ready`=1.
  - `busy`=0, `mismatch`=0, `err_count`=0.
- Latency for a command accepted at edge N into an empty, idle block:
  - j,k driven from edge N+1.
  - Flop updates at edge N+2.
  - Compare registered at edge N+3; `mismatch` visible after N+3.
- Throughput: one command per 2 cycles (DRIVE, CHECK).
- Reset mid-operation: all state clears immediately; buffered commands are discarded and no compare is made. The first command after release is measured against `pred`=0.
- `cmd_ready` depends only on registered FIFO state, with no combinational path from `cmd_valid`.

## Structure
- Package `jk_pkg`:
  - `jk_cmd_t` enum: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
  - `jk_drv_state_t` enum: IDLE, DRIVE, CHECK.
  - Localparam ERR_MAX=8'd255.
- Sub-module `jk_cmd_fifo`:
  - Parameterised DEPTH, 2-bit data.
  - Ports: push, pop, din, dout, full, empty, count.
  - Pointers wrap modulo DEPTH; an extra count bit distinguishes full from empty.
- Top-level content: FSM, reference model, checker.

## Test plan
- Reset, then push 10, 01, 11, 11 back-to-back against a correct `jk`. j,k pulses appear 2 cycles apart; q follows 1,0,1,0; `mismatch`=0 and `err_count`=0 at the end.
- Push 6 commands with DEPTH=4 while the FSM is stalled by back-to-back pushes. `cmd_ready` drops when `fifo_count`=4, no command is lost, and all 6 execute in order.
- Tie `q_in`=0 and `q_bar_in`=1, then push 10 three times. `mismatch`=1 after the first CHECK; `err_count`=3.
- Force failures for 300 commands. `err_count` stays at 255. Pulse `err_clr` in a failing CHECK cycle: `err_count`=1.
- Assert `rst_n`=0 while in DRIVE with 3 commands queued. All outputs return to reset values asynchronously; after release, `fifo_count`=0 and the next toggle predicts q=1.
- CHECK_EN=0 with forced failures: `mismatch` and `err_count` remain 0, and j,k sequencing is unchanged.
